// File: rtl/cv32e40x_mult_seq_pkg.sv
// Shared types and sizing helpers for the iterative EX-stage multiplier.
package cv32e40x_mult_seq_pkg;

  typedef enum logic [1:0] {
    MUL_M32 = 2'b00,
    MUL_H   = 2'b11
  } mul_opcode_e;

  // Default op_b slice width consumed per iteration
  localparam int MULT_SLICE_W_DEFAULT = 16;

  // Accumulator width: shifted partial sum plus one signed (XLEN+1)x(SLICE_W+1)
  // product never exceeds XLEN+SLICE_W+3 bits, so no overflow guard is needed.
  function automatic int mult_acc_w(input int xlen, input int slice_w);
    return xlen + slice_w + 3;
  endfunction

endpackage

// File: rtl/cv32e40x_mult_seq_if.sv
// Pipeline-side handshake and operand bundle of the iterative multiplier.
interface cv32e40x_mult_seq_if #(
  parameter int XLEN = 32
) ();
  import cv32e40x_mult_seq_pkg::*;

  logic              valid_i;
  mul_opcode_e       operator_i;
  logic [1:0]        signed_mode_i;
  logic [XLEN-1:0]   op_a_i;
  logic [XLEN-1:0]   op_b_i;
  logic [XLEN-1:0]   result_o;
  logic              halt_i;
  logic              kill_i;
  logic              ready_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;

  modport master (
    output valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, halt_i, kill_i, ready_i,
    input  result_o, ready_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, halt_i, kill_i, ready_i,
    output result_o, ready_o, valid_o, busy_o
  );

endinterface

// File: rtl/cv32e40x_mult_slice.sv
// One iteration of the multiplier datapath: signed (XLEN+1)x(SLICE_W+1)
// partial product added to the previous accumulator shifted down one slice.
module cv32e40x_mult_slice #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 16,
  parameter int ACC_W   = XLEN + SLICE_W + 3
) (
  input  logic signed [XLEN:0]      a_i,
  input  logic signed [SLICE_W:0]   b_i,
  input  logic signed [ACC_W-1:0]   acc_i,
  output logic signed [ACC_W-1:0]   acc_o
);

  localparam int PROD_W = XLEN + SLICE_W + 2;

  logic signed [PROD_W-1:0] prod;

  assign prod  = a_i * b_i;
  assign acc_o = (acc_i >>> SLICE_W) + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

endmodule

// File: rtl/cv32e40x_mult_seq.sv
// Iterative integer multiplier (MUL / MULH / MULHSU / MULHU) for the EX stage.
// Consumes one SLICE_W-bit slice of op_b per cycle; K = XLEN/SLICE_W cycles
// per operation. Optional build macro CV32E40X_MULT_FAST_MUL_EN adds a
// single-cycle XLEN x XLEN low-product multiplier for MUL_M32.
module cv32e40x_mult_seq
  import cv32e40x_mult_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = MULT_SLICE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  cv32e40x_mult_seq_if.slave  bus
);

  localparam int K     = XLEN / SLICE_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = mult_acc_w(XLEN, SLICE_W);

  if ((XLEN % SLICE_W) != 0) begin : g_chk_div
    $error("cv32e40x_mult_seq: SLICE_W must divide XLEN");
  end
  if (SLICE_W < 8) begin : g_chk_min
    $error("cv32e40x_mult_seq: SLICE_W must be at least 8");
  end
  if ((XLEN != 32) && (XLEN != 64)) begin : g_chk_xlen
    $error("cv32e40x_mult_seq: XLEN must be 32 or 64");
  end

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [XLEN-1:0]          lo_q, lo_d, lo_shift;
  logic signed [XLEN:0]     a_ext;
  logic [SLICE_W-1:0]       b_raw;
  logic signed [SLICE_W:0]  b_slice;
  logic                     last;
  logic                     fast_sel;
  logic [XLEN-1:0]          high;
  logic [XLEN-1:0]          result;
  logic                     valid_o_int;
  logic                     ready_o_int;

  assign last  = (cnt_q == CNT_W'(K - 1));
  assign a_ext = {bus.signed_mode_i[0] & bus.op_a_i[XLEN-1], bus.op_a_i};
  assign b_raw = bus.op_b_i[int'(cnt_q) * SLICE_W +: SLICE_W];
  // Only the most significant slice carries op_b's sign; lower slices are magnitudes.
  assign b_slice = {last & bus.signed_mode_i[1] & bus.op_b_i[XLEN-1], b_raw};

  cv32e40x_mult_slice #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W),
    .ACC_W   (ACC_W)
  ) u_slice (
    .a_i   (a_ext),
    .b_i   (b_slice),
    .acc_i (acc_q),
    .acc_o (acc_next)
  );

  // Low product bits retire SLICE_W at a time into lo_q from the top; for K=1
  // this collapses to acc_next[XLEN-1:0].
  assign lo_shift = XLEN'({acc_next[SLICE_W-1:0], lo_q} >> SLICE_W);
  assign high     = acc_next[SLICE_W +: XLEN];

`ifdef CV32E40X_MULT_FAST_MUL_EN
  logic [XLEN-1:0] fast_low;
  assign fast_low = bus.op_a_i * bus.op_b_i;
  assign fast_sel = (bus.operator_i == MUL_M32);
`else
  assign fast_sel = 1'b0;
`endif

  // Result mux: high or low half of the final accumulation (or the fast product)
  always_comb begin
    result = (bus.operator_i == MUL_H) ? high : lo_shift;
`ifdef CV32E40X_MULT_FAST_MUL_EN
    if (bus.operator_i == MUL_M32) begin
      result = fast_low;
    end
`endif
  end

  // Handshake and next-state: kill beats halt beats iteration
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    valid_o_int = 1'b0;
    ready_o_int = 1'b1;
    if (bus.kill_i) begin
      cnt_d = '0;
      acc_d = '0;
      lo_d  = '0;
    end else if (bus.valid_i) begin
      if (bus.halt_i) begin
        ready_o_int = 1'b0;
      end else if (fast_sel) begin
        valid_o_int = 1'b1;
        ready_o_int = bus.ready_i;
      end else if (last) begin
        // Final slice: result is combinational; state is held until accepted
        valid_o_int = 1'b1;
        ready_o_int = bus.ready_i;
        if (bus.ready_i) begin
          cnt_d = '0;
          acc_d = '0;
          lo_d  = '0;
        end
      end else begin
        ready_o_int = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        acc_d       = acc_next;
        lo_d        = lo_shift;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

  assign bus.result_o = result;
  assign bus.valid_o  = valid_o_int;
  assign bus.ready_o  = ready_o_int;
  assign bus.busy_o   = (cnt_q != '0);

endmodule

// File: tb/tb_cv32e40x_mult_seq.sv
// Self-checking bench for cv32e40x_mult_seq: three configurations
// (32/8, 32/32, 64/16) checked against a wide-arithmetic reference model.
module tb_cv32e40x_mult_seq;
  import cv32e40x_mult_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cv32e40x_mult_seq_if #(.XLEN(32)) bus8 ();
  cv32e40x_mult_seq_if #(.XLEN(32)) bus32 ();
  cv32e40x_mult_seq_if #(.XLEN(64)) bus64 ();

  cv32e40x_mult_seq #(.XLEN(32), .SLICE_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  cv32e40x_mult_seq #(.XLEN(32), .SLICE_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  cv32e40x_mult_seq #(.XLEN(64), .SLICE_W(16)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign/zero-extend both operands to 128 bits and multiply.
  function automatic logic [63:0] ref_mul(input int xlen, input mul_opcode_e op,
                                          input logic [1:0] mode,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask, ea, eb, p;
    mask = (128'd1 << xlen) - 128'd1;
    ea = {64'd0, a} & mask;
    eb = {64'd0, b} & mask;
    if (mode[0] && a[xlen-1]) ea = ea | ~mask;
    if (mode[1] && b[xlen-1]) eb = eb | ~mask;
    p = ea * eb;
    if (op == MUL_H) return 64'((p >> xlen) & mask);
    return 64'(p & mask);
  endfunction

  function automatic int exp_lat(input int k, input mul_opcode_e op);
`ifdef CV32E40X_MULT_FAST_MUL_EN
    if (op == MUL_M32) return 1;
`endif
    return k;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run8(input mul_opcode_e op, input logic [1:0] mode, input logic [31:0] a,
                      input logic [31:0] b, output logic [31:0] res, output int lat);
    res = '0;
    lat = 0;
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = op; bus8.signed_mode_i = mode;
    bus8.op_a_i = a; bus8.op_b_i = b; bus8.ready_i = 1'b1; bus8.halt_i = 1'b0; bus8.kill_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (bus8.valid_o) begin
        res = bus8.result_o;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus8.valid_i = 1'b0;
  endtask

  task automatic run32(input mul_opcode_e op, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    res = '0;
    lat = 0;
    @(negedge clk);
    bus32.valid_i = 1'b1; bus32.operator_i = op; bus32.signed_mode_i = mode;
    bus32.op_a_i = a; bus32.op_b_i = b; bus32.ready_i = 1'b1; bus32.halt_i = 1'b0; bus32.kill_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (bus32.valid_o) begin
        res = bus32.result_o;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
  endtask

  task automatic run64(input mul_opcode_e op, input logic [1:0] mode, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    res = '0;
    lat = 0;
    @(negedge clk);
    bus64.valid_i = 1'b1; bus64.operator_i = op; bus64.signed_mode_i = mode;
    bus64.op_a_i = a; bus64.op_b_i = b; bus64.ready_i = 1'b1; bus64.halt_i = 1'b0; bus64.kill_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (bus64.valid_o) begin
        res = bus64.result_o;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus64.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus8.busy_o); end
    n_tests++; if (bus8.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus8.valid_o); end
    n_tests++; if (bus8.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus8.ready_o); end
    n_tests++; if (bus64.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy64: got %b expected 0", bus64.busy_o); end
  endtask

  task automatic test_vectors();
    logic [31:0] res;
    int lat;
    // Signed min x signed min, cycle-by-cycle
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = MUL_H; bus8.signed_mode_i = 2'b11;
    bus8.op_a_i = 32'h8000_0000; bus8.op_b_i = 32'h8000_0000; bus8.ready_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_tests++; if (bus8.busy_o !== (c > 1)) begin n_fail++; $display("FAIL v1_busy c%0d: got %b expected %b", c, bus8.busy_o, (c > 1)); end
      n_tests++; if (bus8.valid_o !== (c == 4)) begin n_fail++; $display("FAIL v1_valid c%0d: got %b expected %b", c, bus8.valid_o, (c == 4)); end
      n_tests++; if (bus8.ready_o !== (c == 4)) begin n_fail++; $display("FAIL v1_ready c%0d: got %b expected %b", c, bus8.ready_o, (c == 4)); end
      if (c == 4) begin
        n_tests++; if (bus8.result_o !== 32'h4000_0000) begin n_fail++; $display("FAIL v1_result: got %h expected 40000000", bus8.result_o); end
      end
      @(negedge clk);
    end
    bus8.valid_i = 1'b0;
    #1;
    n_tests++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL v1_idle_busy: got %b expected 0", bus8.busy_o); end

    run8(MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_tests++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_ones: got %h expected fffffffe", res); end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL mulhu_lat: got %0d expected 4", lat); end
    run8(MUL_M32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_tests++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_ones: got %h expected 00000001", res); end
    n_tests++; if (lat !== exp_lat(4, MUL_M32)) begin n_fail++; $display("FAIL mul_lat: got %0d expected %0d", lat, exp_lat(4, MUL_M32)); end
    run8(MUL_H, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_ones: got %h expected ffffffff", res); end
    run8(MUL_H, 2'b10, 32'h0000_0003, 32'hFFFF_FFFE, res, lat);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_bsigned: got %h expected ffffffff", res); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    exp = 32'(ref_mul(32, MUL_H, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF));
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = MUL_H; bus8.signed_mode_i = 2'b01;
    bus8.op_a_i = 32'hFFFF_FFFF; bus8.op_b_i = 32'hFFFF_FFFF;
    for (int c = 1; c <= 7; c++) begin
      bus8.ready_i = (c == 7);
      #1;
      n_tests++; if (bus8.valid_o !== (c >= 4)) begin n_fail++; $display("FAIL bp_valid c%0d: got %b expected %b", c, bus8.valid_o, (c >= 4)); end
      if (c >= 4) begin
        n_tests++; if (bus8.result_o !== exp) begin n_fail++; $display("FAIL bp_result c%0d: got %h expected %h", c, bus8.result_o, exp); end
        n_tests++; if (bus8.ready_o !== (c == 7)) begin n_fail++; $display("FAIL bp_ready c%0d: got %b expected %b", c, bus8.ready_o, (c == 7)); end
        n_tests++; if (bus8.busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_busy c%0d: got %b expected 1", c, bus8.busy_o); end
      end
      @(negedge clk);
    end
    bus8.valid_i = 1'b0;
    bus8.ready_i = 1'b1;
    #1;
    n_tests++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", bus8.busy_o); end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = MUL_H; bus8.signed_mode_i = 2'b11;
    bus8.op_a_i = $urandom | 32'h8000_0000; bus8.op_b_i = $urandom | 32'h0101_0101; bus8.ready_i = 1'b1;
    @(negedge clk);
    bus8.kill_i = 1'b1;
    bus8.halt_i = 1'b1;
    #1;
    n_tests++; if (bus8.ready_o !== 1'b1) begin n_fail++; $display("FAIL kill_ready: got %b expected 1", bus8.ready_o); end
    n_tests++; if (bus8.valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_valid: got %b expected 0", bus8.valid_o); end
    @(negedge clk);
    bus8.kill_i = 1'b0;
    bus8.halt_i = 1'b0;
    bus8.valid_i = 1'b0;
    #1;
    n_tests++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b expected 0", bus8.busy_o); end
    run8(MUL_H, 2'b00, 32'h0001_0000, 32'h0001_0000, res, lat);
    n_tests++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL kill_after: got %h expected 00000001", res); end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL kill_after_lat: got %0d expected 4", lat); end
  endtask

  task automatic test_halt();
    logic [31:0] a, b, exp;
    logic [1:0] mode;
    a = $urandom; b = $urandom; mode = 2'($urandom_range(0, 3));
    exp = 32'(ref_mul(32, MUL_H, mode, {32'd0, a}, {32'd0, b}));
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = MUL_H; bus8.signed_mode_i = mode;
    bus8.op_a_i = a; bus8.op_b_i = b; bus8.ready_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      bus8.halt_i = (c == 2) || (c == 3);
      #1;
      n_tests++; if (bus8.valid_o !== (c == 6)) begin n_fail++; $display("FAIL halt_valid c%0d: got %b expected %b", c, bus8.valid_o, (c == 6)); end
      if (c == 2 || c == 3) begin
        n_tests++; if (bus8.ready_o !== 1'b0) begin n_fail++; $display("FAIL halt_ready c%0d: got %b expected 0", c, bus8.ready_o); end
      end
      if (c == 6) begin
        n_tests++; if (bus8.result_o !== exp) begin n_fail++; $display("FAIL halt_result: got %h expected %h", bus8.result_o, exp); end
      end
      @(negedge clk);
    end
    bus8.halt_i = 1'b0;
    bus8.valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, a, b;
    int lat;
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.operator_i = MUL_H; bus8.signed_mode_i = 2'b11;
    bus8.op_a_i = 32'hDEAD_BEEF; bus8.op_b_i = 32'h1234_5678; bus8.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    bus8.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus8.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus8.busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    a = $urandom; b = $urandom;
    run8(MUL_H, 2'b11, a, b, res, lat);
    n_tests++; if (res !== 32'(ref_mul(32, MUL_H, 2'b11, {32'd0, a}, {32'd0, b}))) begin
      n_fail++; $display("FAIL rstmid_result: got %h expected %h", res, 32'(ref_mul(32, MUL_H, 2'b11, {32'd0, a}, {32'd0, b})));
    end
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_lat: got %0d expected 4", lat); end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, res, exp;
    logic [1:0] mode;
    mul_opcode_e op;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = pick32(); b = pick32(); mode = 2'($urandom_range(0, 3));
      op = ($urandom_range(0, 1) == 1) ? MUL_H : MUL_M32;
      exp = 32'(ref_mul(32, op, mode, {32'd0, a}, {32'd0, b}));
      run8(op, mode, a, b, res, lat);
      n_tests++; if (res !== exp || lat !== exp_lat(4, op)) begin
        n_fail++; $display("FAIL rnd32 %0d op%0d m%b %h*%h: got %h lat %0d expected %h lat %0d", i, op, mode, a, b, res, lat, exp, exp_lat(4, op));
      end
    end
  endtask

  task automatic test_single_cycle();
    logic [31:0] a, b, res, exp;
    logic [1:0] mode;
    mul_opcode_e op;
    int lat;
    run32(MUL_H, 2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, res, lat);
    n_tests++; if (res !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL k1_vec: got %h expected 3fffffff", res); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL k1_lat: got %0d expected 1", lat); end
    for (int i = 0; i < 12; i++) begin
      a = pick32(); b = pick32(); mode = 2'($urandom_range(0, 3));
      op = ($urandom_range(0, 1) == 1) ? MUL_H : MUL_M32;
      exp = 32'(ref_mul(32, op, mode, {32'd0, a}, {32'd0, b}));
      run32(op, mode, a, b, res, lat);
      n_tests++; if (res !== exp || lat !== 1) begin
        n_fail++; $display("FAIL k1_rnd %0d op%0d m%b %h*%h: got %h lat %0d expected %h lat 1", i, op, mode, a, b, res, lat, exp);
      end
    end
  endtask

  task automatic test_random64();
    logic [63:0] a, b, res, exp;
    logic [1:0] mode;
    mul_opcode_e op;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (i % 8 == 0) a = 64'h8000_0000_0000_0000;
      if (i % 8 == 1) b = 64'hFFFF_FFFF_FFFF_FFFF;
      mode = 2'(i % 4);
      op = ($urandom_range(0, 1) == 1) ? MUL_H : MUL_M32;
      exp = ref_mul(64, op, mode, a, b);
      run64(op, mode, a, b, res, lat);
      n_tests++; if (res !== exp || lat !== exp_lat(4, op)) begin
        n_fail++; $display("FAIL rnd64 %0d op%0d m%b %h*%h: got %h lat %0d expected %h lat %0d", i, op, mode, a, b, res, lat, exp, exp_lat(4, op));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus8.valid_i = 1'b0; bus8.operator_i = MUL_M32; bus8.signed_mode_i = 2'b00; bus8.op_a_i = '0;
    bus8.op_b_i = '0; bus8.halt_i = 1'b0; bus8.kill_i = 1'b0; bus8.ready_i = 1'b1;
    bus32.valid_i = 1'b0; bus32.operator_i = MUL_M32; bus32.signed_mode_i = 2'b00; bus32.op_a_i = '0;
    bus32.op_b_i = '0; bus32.halt_i = 1'b0; bus32.kill_i = 1'b0; bus32.ready_i = 1'b1;
    bus64.valid_i = 1'b0; bus64.operator_i = MUL_M32; bus64.signed_mode_i = 2'b00; bus64.op_a_i = '0;
    bus64.op_b_i = '0; bus64.halt_i = 1'b0; bus64.kill_i = 1'b0; bus64.ready_i = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_kill();
    test_halt();
    test_reset_mid();
    test_random32();
    test_single_cycle();
    test_random64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
